// File: rtl/sh_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : sh_sync_gen
// Desc     : Sample-and-hold sync generator. RX mode averages the rfin period
//            and emits a phase-centred sh_en packet; TX mode emits a fixed
//            interval packet per tx_rdy edge. Lock monitor: SH_SYNC_LOCK_MON_EN.
// Revision : 1.0
// ============================================================================
module sh_sync_gen #(
    parameter int CNT_W         = 16,
    parameter int AVG_LOG2      = 3,
    parameter int PACKET_SIZE   = 64,
    parameter int TIMEOUT       = 20000,
    parameter int MIN_INTERVAL  = 100,
    parameter int TX_INTERVAL   = 10000,
    parameter int LOCK_TOL_LOG2 = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 rfin,
    input  logic                                 RX,
    input  logic                                 tx_rdy,
    output logic                                 sh_en,
    output logic                                 fsm_rst,
    output logic                                 locked,
    output logic                                 lock_lost,
    output logic [CNT_W-1:0]                     avg_interval,
    output logic [$clog2(PACKET_SIZE+1)-1:0]     pulse_idx
);

    localparam int PI_W  = $clog2(PACKET_SIZE+1);
    localparam int SUM_W = CNT_W + AVG_LOG2;
    localparam int N_W   = AVG_LOG2 + 1;

    localparam logic [CNT_W-1:0] C_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_TX_M1      = CNT_W'(TX_INTERVAL - 1);
    localparam logic [CNT_W:0]   C_MIN        = (CNT_W+1)'(MIN_INTERVAL);
    localparam logic [N_W-1:0]   C_N_LAST     = N_W'((1 << AVG_LOG2) - 1);
    localparam logic [PI_W-1:0]  C_PI_LAST    = PI_W'(PACKET_SIZE - 1);

`ifdef SH_SYNC_LOCK_MON_EN
    localparam bit C_LOCK_MON = 1'b1;
`else
    localparam bit C_LOCK_MON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COLLECT    = 3'd1,
        S_COMPUTE    = 3'd2,
        S_GENERATE   = 3'd3,
        S_WAIT_TXRDY = 3'd4,
        S_SEND_TX    = 3'd5
    } state_t;

    state_t r_state, w_next;

    logic r_rf_s1, r_rf_s2, r_rf_s3, r_rf_edge;
    logic r_tx_d, r_tx_edge;

    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] r_sum;
    logic [N_W-1:0]   r_n;
    logic [CNT_W-1:0] r_timer;
    logic             r_miss;

    logic             r_sh_en, r_fsm_rst, r_locked, r_lock_lost;
    logic [CNT_W-1:0] r_avg;
    logic [PI_W-1:0]  r_pulse_idx;

    logic [CNT_W:0]   w_cnt_inc;
    logic [CNT_W-1:0] w_avg, w_half, w_h_m1, w_avg_m1;
    logic [CNT_W:0]   w_avg_ext, w_diff, w_tol;
    logic             w_miss, w_lock_fail;
    logic             w_start, w_accept, w_timeout, w_fire;

    // rfin: two-flop synchroniser, then a registered rising-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_s1   <= 1'b0;
            r_rf_s2   <= 1'b0;
            r_rf_s3   <= 1'b0;
            r_rf_edge <= 1'b0;
            r_tx_d    <= 1'b0;
            r_tx_edge <= 1'b0;
        end else begin
            r_rf_s1   <= rfin;
            r_rf_s2   <= r_rf_s1;
            r_rf_s3   <= r_rf_s2;
            r_rf_edge <= r_rf_s2 & ~r_rf_s3;
            r_tx_d    <= tx_rdy;
            r_tx_edge <= tx_rdy & ~r_tx_d;
        end
    end

    always_comb begin
        w_cnt_inc = {1'b0, r_cnt} + 1'b1;
        w_avg     = r_sum[SUM_W-1 -: CNT_W];
        w_half    = w_avg >> 1;
        w_h_m1    = (w_half == '0) ? '0 : w_half - 1'b1;
        w_avg_m1  = (r_avg == '0) ? '0 : r_avg - 1'b1;
        w_avg_ext = {1'b0, r_avg};
        w_diff    = (w_cnt_inc > w_avg_ext) ? (w_cnt_inc - w_avg_ext) : (w_avg_ext - w_cnt_inc);
        w_tol     = w_avg_ext >> LOCK_TOL_LOG2;
        w_miss    = (w_diff > w_tol);
    end

    // Second consecutive out-of-tolerance interval while generating drops lock
    assign w_lock_fail = C_LOCK_MON && (r_state == S_GENERATE) && RX
                         && r_rf_edge && w_miss && r_miss;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_accept  = 1'b0;
        w_timeout = 1'b0;
        w_fire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!RX) begin
                    w_next = S_WAIT_TXRDY;
                end else if (r_rf_edge) begin
                    w_next  = S_COLLECT;
                    w_start = 1'b1;
                end
            end
            S_COLLECT: begin
                if (!RX) begin
                    w_next = S_IDLE;
                end else if (r_rf_edge && (w_cnt_inc >= C_MIN)) begin
                    w_accept = 1'b1;
                    if (r_n == C_N_LAST) w_next = S_COMPUTE;
                end else if (r_cnt == C_TIMEOUT_M1) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_COMPUTE: w_next = S_GENERATE;
            S_GENERATE: begin
                if (!RX || w_lock_fail) begin
                    w_next = S_IDLE;
                end else if (r_timer == '0) begin
                    w_fire = 1'b1;
                    if (r_pulse_idx == C_PI_LAST) w_next = S_IDLE;
                end
            end
            S_WAIT_TXRDY: begin
                if (RX)             w_next = S_IDLE;
                else if (r_tx_edge) w_next = S_SEND_TX;
            end
            S_SEND_TX: begin
                if (RX) begin
                    w_next = S_IDLE;
                end else if (r_timer == '0) begin
                    w_fire = 1'b1;
                    if (r_pulse_idx == C_PI_LAST) w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_sum       <= '0;
            r_n         <= '0;
            r_timer     <= '0;
            r_miss      <= 1'b0;
            r_sh_en     <= 1'b0;
            r_fsm_rst   <= 1'b0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
            r_avg       <= '0;
            r_pulse_idx <= '0;
        end else begin
            r_sh_en     <= w_fire;
            r_fsm_rst   <= w_accept | w_timeout;
            r_lock_lost <= w_lock_fail;

            // Interval counter saturates at the timeout and never wraps
            if (w_start || w_accept || (r_state == S_GENERATE && r_rf_edge))
                r_cnt <= '0;
            else if (r_cnt != C_TIMEOUT_M1)
                r_cnt <= r_cnt + 1'b1;

            if (w_start) begin
                r_sum <= '0;
                r_n   <= '0;
            end else if (w_accept) begin
                r_sum <= r_sum + SUM_W'(w_cnt_inc);
                r_n   <= r_n + 1'b1;
            end

            if (C_LOCK_MON && r_state == S_GENERATE) begin
                if (r_rf_edge) r_miss <= w_miss;
            end else begin
                r_miss <= 1'b0;
            end

            if (w_start || w_lock_fail)   r_locked <= 1'b0;
            else if (r_state == S_COMPUTE) r_locked <= 1'b1;

            if (r_state == S_COMPUTE) r_avg <= w_avg;

            // First RX pulse lands half a period in; first TX pulse the cycle after entry
            if (r_state == S_COMPUTE)
                r_timer <= w_h_m1;
            else if (r_state == S_WAIT_TXRDY && w_next == S_SEND_TX)
                r_timer <= '0;
            else if (w_fire)
                r_timer <= (r_state == S_GENERATE) ? w_avg_m1 : C_TX_M1;
            else if (r_timer != '0)
                r_timer <= r_timer - 1'b1;

            if (r_state == S_IDLE) r_pulse_idx <= '0;
            else if (w_fire)       r_pulse_idx <= r_pulse_idx + 1'b1;
        end
    end

    assign sh_en        = r_sh_en;
    assign fsm_rst      = r_fsm_rst;
    assign locked       = r_locked;
    assign lock_lost    = r_lock_lost;
    assign avg_interval = r_avg;
    assign pulse_idx    = r_pulse_idx;

endmodule
`default_nettype wire

// File: tb/tb_sh_sync_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_sh_sync_gen
// Desc     : Directed, table-driven bench for sh_sync_gen with scaled timing.
// Revision : 1.0
// ============================================================================
module tb_sh_sync_gen;

    localparam int CNT_W    = 16;
    localparam int AVG_LOG2 = 3;
    localparam int PKT      = 8;
    localparam int TMO      = 400;
    localparam int MINI     = 20;
    localparam int TXI      = 50;
    localparam int TOL      = 2;
    localparam int PI_W     = $clog2(PKT+1);

    logic             clk = 1'b0;
    logic             rst, rfin, RX, tx_rdy;
    logic             sh_en, fsm_rst, locked, lock_lost;
    logic [CNT_W-1:0] avg_interval;
    logic [PI_W-1:0]  pulse_idx;

    sh_sync_gen #(
        .CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .PACKET_SIZE(PKT), .TIMEOUT(TMO),
        .MIN_INTERVAL(MINI), .TX_INTERVAL(TXI), .LOCK_TOL_LOG2(TOL)
    ) dut (
        .clk(clk), .rst(rst), .rfin(rfin), .RX(RX), .tx_rdy(tx_rdy),
        .sh_en(sh_en), .fsm_rst(fsm_rst), .locked(locked), .lock_lost(lock_lost),
        .avg_interval(avg_interval), .pulse_idx(pulse_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge
    int n_fsm = 0, last_fsm = 0, prev_fsm = 0, n_sh = 0, n_ll = 0;
    int sh_cyc [256];
    always @(negedge clk) begin
        if (fsm_rst) begin
            n_fsm    <= n_fsm + 1;
            prev_fsm <= last_fsm;
            last_fsm <= cyc;
        end
        if (sh_en) begin
            if (n_sh < 256) sh_cyc[n_sh] <= cyc;
            n_sh <= n_sh + 1;
        end
        if (lock_lost) n_ll <= n_ll + 1;
    end

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rf_edge();
        rfin = 1'b1;
        step(2);
        rfin = 1'b0;
    endtask

    // Nine edges: intervals alternate p_even/p_odd, optional sub-minimum glitch in interval 3
    task automatic run_edges(input int p_even, input int p_odd, input bit glitch);
        for (int k = 0; k < 9; k++) begin
            rf_edge();
            if (k < 8) begin
                if (glitch && k == 3) begin
                    step(6);
                    rf_edge();
                    step(((k % 2 == 0) ? p_even : p_odd) - 10);
                end else begin
                    step(((k % 2 == 0) ? p_even : p_odd) - 2);
                end
            end
        end
    endtask

    typedef struct {
        int p_even;
        int p_odd;
        bit glitch;
        int exp_avg;
        int exp_h;
    } rx_vec_t;

    rx_vec_t vecs [6];

    int b_fsm, b_sh, b_ll, c0;

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{100, 100, 1'b0, 100, 50};
        vecs[1] = '{ 99, 102, 1'b0, 100, 50};
        vecs[2] = '{100, 100, 1'b1, 100, 50};
        vecs[3] = '{ 60,  61, 1'b0,  60, 30};
        vecs[4] = '{ 41,  41, 1'b0,  41, 20};
        vecs[5] = '{ 20,  20, 1'b0,  20, 10};

        rst = 1'b1; rfin = 1'b0; RX = 1'b1; tx_rdy = 1'b0;
        step(5);
        chk("rst_sh_en", 0, int'(sh_en), 0);
        chk("rst_fsm_rst", 0, int'(fsm_rst), 0);
        chk("rst_locked", 0, int'(locked), 0);
        chk("rst_lock_lost", 0, int'(lock_lost), 0);
        chk("rst_avg", 0, int'(avg_interval), 0);
        chk("rst_pulse_idx", 0, int'(pulse_idx), 0);
        rst = 1'b0;
        step(5);

        for (int v = 0; v < 6; v++) begin
            b_fsm = n_fsm; b_sh = n_sh;
            run_edges(vecs[v].p_even, vecs[v].p_odd, vecs[v].glitch);
            step(vecs[v].exp_h + vecs[v].exp_avg * PKT + 40);
            chk("rx_fsm_rst_cnt", v, n_fsm - b_fsm, 8);
            chk("rx_avg", v, int'(avg_interval), vecs[v].exp_avg);
            chk("rx_locked", v, int'(locked), 1);
            chk("rx_sh_cnt", v, n_sh - b_sh, PKT);
            chk("rx_first_delay", v, sh_cyc[b_sh] - last_fsm, vecs[v].exp_h + 1);
            chk("rx_spacing_first", v, sh_cyc[b_sh+1] - sh_cyc[b_sh], vecs[v].exp_avg);
            chk("rx_spacing_last", v, sh_cyc[b_sh+PKT-1] - sh_cyc[b_sh+PKT-2], vecs[v].exp_avg);
            chk("rx_pulse_idx_end", v, int'(pulse_idx), 0);
        end

        // Collection stalls after three edges
        b_fsm = n_fsm; b_sh = n_sh;
        rf_edge(); step(98); rf_edge(); step(98); rf_edge();
        step(30);
        chk("tmo_locked_cleared", 0, int'(locked), 0);
        step(450);
        chk("tmo_fsm_rst_cnt", 0, n_fsm - b_fsm, 3);
        chk("tmo_gap", 0, last_fsm - prev_fsm, TMO);
        chk("tmo_sh_cnt", 0, n_sh - b_sh, 0);
        chk("tmo_locked", 0, int'(locked), 0);

        // Reset mid-packet
        b_sh = n_sh;
        run_edges(100, 100, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if (n_sh - b_sh >= 1) break;
            step(1);
        end
        step(5);
        chk("rstm_pulse_idx_pre", 0, int'(pulse_idx), 1);
        rst = 1'b1;
        step(1);
        chk("rstm_sh_en", 0, int'(sh_en), 0);
        chk("rstm_locked", 0, int'(locked), 0);
        chk("rstm_avg", 0, int'(avg_interval), 0);
        chk("rstm_pulse_idx", 0, int'(pulse_idx), 0);
        rst = 1'b0;
        step(300);
        chk("rstm_sh_cnt", 0, n_sh - b_sh, 1);

        // TX full packet
        RX = 1'b0;
        step(3);
        b_sh = n_sh;
        tx_rdy = 1'b1;
        c0 = cyc;
        step(PKT * TXI + 20);
        chk("tx_sh_cnt", 0, n_sh - b_sh, PKT);
        chk("tx_latency", 0, sh_cyc[b_sh] - c0, 3);
        chk("tx_spacing_first", 0, sh_cyc[b_sh+1] - sh_cyc[b_sh], TXI);
        chk("tx_spacing_last", 0, sh_cyc[b_sh+PKT-1] - sh_cyc[b_sh+PKT-2], TXI);
        chk("tx_pulse_idx_end", 0, int'(pulse_idx), 0);

        // TX aborted by RX after the second pulse
        tx_rdy = 1'b0;
        step(3);
        b_sh = n_sh;
        tx_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (n_sh - b_sh >= 2) break;
            step(1);
        end
        chk("txab_pulse_idx_pre", 0, int'(pulse_idx), 2);
        RX = 1'b1;
        step(5);
        chk("txab_pulse_idx", 0, int'(pulse_idx), 0);
        step(150);
        chk("txab_sh_cnt", 0, n_sh - b_sh, 2);

        // RX wins over a simultaneous tx_rdy edge
        RX = 1'b0; tx_rdy = 1'b0;
        step(4);
        b_sh = n_sh;
        tx_rdy = 1'b1;
        step(1);
        RX = 1'b1;
        step(1);
        RX = 1'b0;
        step(100);
        chk("prio_sh_cnt", 0, n_sh - b_sh, 0);
        RX = 1'b1; tx_rdy = 1'b0;
        step(5);

`ifdef SH_SYNC_LOCK_MON_EN
        b_sh = n_sh; b_ll = n_ll;
        run_edges(100, 100, 1'b0);
        step(98); rf_edge();
        step(128); rf_edge();
        step(128); rf_edge();
        step(400);
        chk("lm_lock_lost_cnt", 0, n_ll - b_ll, 1);
        chk("lm_locked", 0, int'(locked), 0);
        chk("lm_sh_cnt", 0, n_sh - b_sh, 4);
`else
        b_ll = 0;
        chk("lock_lost_never", 0, n_ll - b_ll, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
